mouse_bus_peripheral: RTL
=========================

// Module: mouse_bus_peripheral
// PURPOSE
//  Bus-side responder for the mouse transceiver: captures each completed PS/2 packet, tracks a clamped
//  absolute pointer position and raises a processor interrupt. Exposes the packet and position as
//  memory-mapped registers on the shared 8-bit BUS_DATA/BUS_ADDR/BUS_WE bus. Sits beside the RAM as a
//  bus slave; its interrupt pair connects to one bit of BUS_INTERRUPTS_RAISE/ACK.
// PARAMETERS
//  BASE_ADDR  8'hA0  first of 8 consecutive register addresses (BASE_ADDR..BASE_ADDR+7)
//  X_MAX      8'd159 inclusive upper clamp of X position
//  Y_MAX      8'd119 inclusive upper clamp of Y position
// PORTS
//  CLK                  in     1  system clock (50 MHz)
//  RESET                in     1  synchronous, active-high reset
//  BUS_DATA             inout  8  shared data bus; driven only during a read response, else high-Z
//  BUS_ADDR             in     8  bus address from processor
//  BUS_WE               in     1  1 = processor write, 0 = read
//  MOUSE_STATUS         in     8  PS/2 byte 0: [0]L [1]R [4]X sign [5]Y sign [6]X ovf [7]Y ovf
//  MOUSE_DX             in     8  PS/2 X magnitude byte (two's complement low bits)
//  MOUSE_DY             in     8  PS/2 Y magnitude byte
//  MOUSE_PKT_VALID      in     1  1-cycle pulse: the three mouse bytes above are valid this cycle
//  BUS_INTERRUPT_RAISE  out    1  interrupt request to processor
//  BUS_INTERRUPT_ACK    in     1  1-cycle acknowledge from processor
// BEHAVIOUR
//  Reset: STATUS/DX/DY/LOST = 0, X = X_MAX>>1, Y = Y_MAX>>1, CTRL = 8'h01, FSM = IDLE,
//   BUS_INTERRUPT_RAISE = 0, BUS_DATA high-Z. RESET overrides every event in the same cycle.
//  Register map (offset from BASE_ADDR):
//   0 STATUS, 1 DX, 2 DY, 3 X, 4 Y (R); 5 LOST (R) = packets arriving while a request was pending
//   6 IRQ (R) = {7'b0, BUS_INTERRUPT_RAISE}; 7 CTRL (R/W) = [0] IRQ enable, [1] CLEAR_POS (self-clearing)
//  Packet capture (cycle of MOUSE_PKT_VALID): STATUS/DX/DY latch the inputs; new values are readable next cycle.
//  Position update, same edge:
//   dx9 = {STATUS[4], DX}, dy9 = {STATUS[5], DY}, both signed 9-bit.
//   X' = clamp(X + dx9, 0, X_MAX); Y' = clamp(Y - dy9, 0, Y_MAX). Y is screen-down.
//   Use a >=10-bit signed intermediate; no wrap-around at any input.
//   Axis overflow bit set (STATUS[6] for X, [7] for Y): that axis is held unchanged.
//  Bus write: BUS_WE=1 and BUS_ADDR==BASE_ADDR+7 -> CTRL[0] <= BUS_DATA[0].
//   If BUS_DATA[1]=1: X,Y <= centre next edge; CTRL[1] always reads 0.
//   Writes to offsets 0-6 are ignored.
//  Clear vs packet in the same cycle: clear wins for X/Y; STATUS/DX/DY still latch.
//  Bus read: BUS_WE=0 and BUS_ADDR in BASE..BASE+7 at edge N -> registered data and drive-enable set.
//   BUS_DATA is driven from edge N until the edge after the address leaves range or BUS_WE=1
//   (1-cycle latency, glitch-free). Out-of-range address -> high-Z.
//  Interrupt FSM:
//   IDLE  -> RAISE when MOUSE_PKT_VALID && CTRL[0]; BUS_INTERRUPT_RAISE = 1 from the next cycle.
//   RAISE -> IDLE on BUS_INTERRUPT_ACK; RAISE drops the next cycle.
//   Packet while in RAISE without ACK: registers update; LOST += 1, saturating at 8'hFF.
//   Packet and ACK same cycle: stay in RAISE (request re-armed), LOST unchanged.
//   ACK while IDLE: ignored. Clearing CTRL[0] while in RAISE: no effect until ACK.
//  Reads never clear state; LOST is cleared only by RESET.
// TESTING
//  Reset, read offsets 3/4 -> 8'd79 / 8'd59; BUS_DATA high-Z at addr 8'h00; RAISE=0.
//  Pkt STATUS=8'h00 DX=8'h05 DY=8'h03 -> X=84, Y=56, RAISE 1 cycle after pulse; ACK -> RAISE=0 next cycle.
//  Pkt STATUS=8'h10 DX=8'h80 (dx=-128) from X=84 -> X=0; then DX=8'h7F x2 -> X clamps at 159.
//  Three pkts without ACK -> LOST=2; pkt and ACK in same cycle -> RAISE stays 1, LOST=2.
//  Write 8'h02 to BASE+7 in the same cycle as a pkt -> X=79, Y=59, CTRL reads 8'h00, no RAISE on next pkt.
//  Pkt with STATUS[6]=1 -> X unchanged; RESET asserted while RAISE=1 -> all reset values next cycle.

Source files
------------

// File: rtl/mouse_bus_peripheral.sv
// rtl/mouse_bus_peripheral.sv - PS/2 mouse packet capture, clamped pointer position and bus-mapped registers with interrupt
module mouse_bus_peripheral #(
    parameter logic [7:0] BASE_ADDR = 8'hA0,
    parameter logic [7:0] X_MAX     = 8'd159,
    parameter logic [7:0] Y_MAX     = 8'd119
) (
    input  logic       CLK,
    input  logic       RESET,
    inout  wire  [7:0] BUS_DATA,
    input  logic [7:0] BUS_ADDR,
    input  logic       BUS_WE,
    input  logic [7:0] MOUSE_STATUS,
    input  logic [7:0] MOUSE_DX,
    input  logic [7:0] MOUSE_DY,
    input  logic       MOUSE_PKT_VALID,
    output logic       BUS_INTERRUPT_RAISE,
    input  logic       BUS_INTERRUPT_ACK
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_RAISE = 1'b1
    } irq_state_t;

    localparam logic [7:0] X_CENTRE = X_MAX >> 1;
    localparam logic [7:0] Y_CENTRE = Y_MAX >> 1;

    irq_state_t state_q, state_d;
    logic [7:0] status_q, status_d;
    logic [7:0] dx_q, dx_d;
    logic [7:0] dy_q, dy_d;
    logic [7:0] x_q, x_d;
    logic [7:0] y_q, y_d;
    logic [7:0] lost_q, lost_d;
    logic       irq_en_q, irq_en_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       rd_en_q, rd_en_d;

    logic             in_range;
    logic [7:0]       offset;
    logic             ctrl_wr;
    logic             clear_pos;
    logic [7:0]       bus_din;
    logic signed [10:0] dx_ext;
    logic signed [10:0] dy_ext;
    logic signed [10:0] x_sum;
    logic signed [10:0] y_sum;
    logic             unused_bus_bits;

    // Clamp a wide signed sum into [0, max]; the sum never wraps at 11 bits.
    function automatic logic [7:0] clamp(input logic signed [10:0] v, input logic [7:0] max);
        if (v < 11'sd0) begin
            return 8'd0;
        end else if (v > $signed({3'b000, max})) begin
            return max;
        end else begin
            return v[7:0];
        end
    endfunction

    assign bus_din         = BUS_DATA;
    assign unused_bus_bits = ^bus_din[7:2];

    assign offset    = BUS_ADDR - BASE_ADDR;
    assign in_range  = ({1'b0, BUS_ADDR} >= {1'b0, BASE_ADDR}) &&
                       ({1'b0, BUS_ADDR} <= ({1'b0, BASE_ADDR} + 9'd7));
    assign ctrl_wr   = BUS_WE && in_range && (offset[2:0] == 3'd7);
    assign clear_pos = ctrl_wr && bus_din[1];

    assign dx_ext = {{3{MOUSE_STATUS[4]}}, MOUSE_DX};
    assign dy_ext = {{3{MOUSE_STATUS[5]}}, MOUSE_DY};
    assign x_sum  = $signed({3'b000, x_q}) + dx_ext;
    assign y_sum  = $signed({3'b000, y_q}) - dy_ext;

    always_comb begin
        state_d   = state_q;
        status_d  = status_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        x_d       = x_q;
        y_d       = y_q;
        lost_d    = lost_q;
        irq_en_d  = irq_en_q;
        rd_data_d = rd_data_q;
        rd_en_d   = 1'b0;

        if (MOUSE_PKT_VALID) begin
            status_d = MOUSE_STATUS;
            dx_d     = MOUSE_DX;
            dy_d     = MOUSE_DY;
            if (!MOUSE_STATUS[6]) begin
                x_d = clamp(x_sum, X_MAX);
            end
            if (!MOUSE_STATUS[7]) begin
                y_d = clamp(y_sum, Y_MAX);
            end
        end

        if (ctrl_wr) begin
            irq_en_d = bus_din[0];
        end
        // Centring beats a same-cycle packet; the packet bytes still latch above.
        if (clear_pos) begin
            x_d = X_CENTRE;
            y_d = Y_CENTRE;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (MOUSE_PKT_VALID && irq_en_q) begin
                    state_d = ST_RAISE;
                end
            end
            ST_RAISE: begin
                if (BUS_INTERRUPT_ACK) begin
                    if (!MOUSE_PKT_VALID) begin
                        state_d = ST_IDLE;
                    end
                end else if (MOUSE_PKT_VALID && (lost_q != 8'hFF)) begin
                    lost_d = lost_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!BUS_WE && in_range) begin
            rd_en_d = 1'b1;
            unique case (offset[2:0])
                3'd0: rd_data_d = status_q;
                3'd1: rd_data_d = dx_q;
                3'd2: rd_data_d = dy_q;
                3'd3: rd_data_d = x_q;
                3'd4: rd_data_d = y_q;
                3'd5: rd_data_d = lost_q;
                3'd6: rd_data_d = {7'b0, (state_q == ST_RAISE)};
                3'd7: rd_data_d = {7'b0, irq_en_q};
                default: rd_data_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            status_q  <= 8'h00;
            dx_q      <= 8'h00;
            dy_q      <= 8'h00;
            x_q       <= X_CENTRE;
            y_q       <= Y_CENTRE;
            lost_q    <= 8'h00;
            irq_en_q  <= 1'b1;
            rd_data_q <= 8'h00;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            status_q  <= status_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            x_q       <= x_d;
            y_q       <= y_d;
            lost_q    <= lost_d;
            irq_en_q  <= irq_en_d;
            rd_data_q <= rd_data_d;
            rd_en_q   <= rd_en_d;
        end
    end

    assign BUS_INTERRUPT_RAISE = (state_q == ST_RAISE);
    assign BUS_DATA            = rd_en_q ? rd_data_q : 8'hzz;

endmodule
